// File: rtl/ch_seq_ctrl.sv
// Per-channel sampling sequencer: walks a channel through its fast sample buffers,
// 2**mode buffers per trigger, and raises STOP_REQUEST once every buffer group is used.
module ch_seq_ctrl #(
  parameter int N_BUF  = 4,
  parameter int MODE_W = $clog2($clog2(N_BUF) + 1),
  parameter int CNT_W  = $clog2(N_BUF + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              trigger,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic              INST_STOP,
  input  logic              INST_READOUT,
  output logic [2:0]        current_state,
  output logic [N_BUF-1:0]  buf_en,
  output logic [CNT_W-1:0]  trigger_cnt,
  output logic              STOP_REQUEST,
  output logic              overflow
);

  localparam int LOG2 = $clog2(N_BUF);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    SAMPLING = 3'd1,
    FULL     = 3'd2,
    STOPPED  = 3'd3,
    READOUT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [MODE_W-1:0] m_q, m_d, mode_eff;
  logic [LOG2-1:0]   grp_q, grp_d, last_grp;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              ovf_q, ovf_d;
  logic              trig_q, trig_rise;
  logic [N_BUF-1:0]  buf_en_q, buf_en_d;

  assign trig_rise = trigger & ~trig_q;
  // Out-of-range modes clamp to a single group spanning every buffer.
  assign mode_eff  = (mode > MODE_W'(LOG2)) ? MODE_W'(LOG2) : mode;
  assign last_grp  = LOG2'((N_BUF >> m_q) - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= INIT;
      m_q      <= '0;
      grp_q    <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      trig_q   <= 1'b0;
      buf_en_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      grp_q    <= grp_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      ovf_q    <= ovf_d;
      trig_q   <= trigger;
      buf_en_q <= buf_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    ovf_d   = ovf_q;
    if (INST_READOUT) begin
      state_d = READOUT;
    end else if (INST_STOP) begin
      state_d = STOPPED;
    end else if (start) begin
      state_d = SAMPLING;
      m_d     = mode_eff;
      grp_d   = '0;
      cnt_d   = '0;
      stop_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (trig_rise) begin
      case (state_q)
        SAMPLING: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (grp_q == last_grp) begin
            state_d = FULL;
            stop_d  = 1'b1;
          end else begin
            grp_d = grp_q + LOG2'(1);
          end
        end
        // The count already sits at the group total here, so holding it saturates it.
        FULL:    ovf_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Decode from next-state values so buf_en leaves the register aligned with the state.
  always_comb begin
    buf_en_d = '0;
    for (int i = 0; i < N_BUF; i++) begin
      buf_en_d[i] = (state_d == SAMPLING) && (LOG2'(i >> m_d) == grp_d);
    end
  end

  assign current_state = state_q;
  assign buf_en        = buf_en_q;
  assign trigger_cnt   = cnt_q;
  assign STOP_REQUEST  = stop_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_ch_seq_ctrl.sv
// Bench for ch_seq_ctrl: directed vector table followed by random stimulus
// checked against a count-based reference model.
module tb_ch_seq_ctrl;

  localparam int N_BUF  = 4;
  localparam int MODE_W = 2;
  localparam int CNT_W  = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              trigger = 1'b0;
  logic              start = 1'b0;
  logic [MODE_W-1:0] mode = '0;
  logic              INST_STOP = 1'b0;
  logic              INST_READOUT = 1'b0;
  logic [2:0]        current_state;
  logic [N_BUF-1:0]  buf_en;
  logic [CNT_W-1:0]  trigger_cnt;
  logic              STOP_REQUEST;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  ch_seq_ctrl #(.N_BUF(N_BUF)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .trigger      (trigger),
    .start        (start),
    .mode         (mode),
    .INST_STOP    (INST_STOP),
    .INST_READOUT (INST_READOUT),
    .current_state(current_state),
    .buf_en       (buf_en),
    .trigger_cnt  (trigger_cnt),
    .STOP_REQUEST (STOP_REQUEST),
    .overflow     (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, trig, st, stp, rdo;
    logic [1:0] md;
    logic [2:0] e_state;
    logic [3:0] e_en;
    logic [2:0] e_cnt;
    logic       e_sreq, e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, trig, st, input logic [1:0] md, input logic stp, rdo,
                        input logic [2:0] e_state, input logic [3:0] e_en, input logic [2:0] e_cnt,
                        input logic e_sreq, e_ovf);
    vec_t v;
    v.rst = rst; v.trig = trig; v.st = st; v.md = md; v.stp = stp; v.rdo = rdo;
    v.e_state = e_state; v.e_en = e_en; v.e_cnt = e_cnt; v.e_sreq = e_sreq; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, trig, st, input logic [1:0] md, input logic stp, rdo);
    @(negedge CLK);
    RST = rst; trigger = trig; start = st; mode = md; INST_STOP = stp; INST_READOUT = rdo;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model: tracks captured triggers and buffers per trigger; the active
  // group is simply the number of triggers captured so far.
  int  mState, mCnt, mBpt;
  bit  mSreq, mOvf, mPrevTrig;

  task automatic modelStep(input bit rst, trig, st, input int md, input bit stp, rdo);
    bit rise;
    rise = trig && !mPrevTrig;
    mPrevTrig = trig;
    if (rst) begin
      mState = 0; mCnt = 0; mBpt = 1; mSreq = 0; mOvf = 0; mPrevTrig = 0;
    end else if (rdo) begin
      mState = 4;
    end else if (stp) begin
      mState = 3;
    end else if (st) begin
      mBpt = 1 << ((md > 2) ? 2 : md);
      mState = 1; mCnt = 0; mSreq = 0; mOvf = 0;
    end else if (rise) begin
      if (mState == 1) begin
        mCnt++;
        if (mCnt == N_BUF / mBpt) begin
          mState = 2;
          mSreq = 1;
        end
      end else if (mState == 2) begin
        mOvf = 1;
      end
    end
  endtask

  function automatic int modelEn();
    if (mState != 1) return 0;
    return (((1 << mBpt) - 1) << (mCnt * mBpt)) & ((1 << N_BUF) - 1);
  endfunction

  initial begin
    // rst trig start mode stop rdout | state en cnt sreq ovf
    addVec(1,0,0,0,0,0, 0,4'b0000,0,0,0);
    addVec(0,0,1,0,0,0, 1,4'b0001,0,0,0);
    addVec(0,1,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,1,0,0,0,0, 1,4'b0100,2,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0100,2,0,0);
    addVec(0,1,0,0,0,0, 1,4'b1000,3,0,0);
    addVec(0,0,0,0,0,0, 1,4'b1000,3,0,0);
    addVec(0,1,0,0,0,0, 2,4'b0000,4,1,0);
    addVec(0,0,0,0,0,0, 2,4'b0000,4,1,0);
    addVec(0,0,1,1,0,0, 1,4'b0011,0,0,0);
    addVec(0,1,0,0,0,0, 1,4'b1100,1,0,0);
    addVec(0,0,0,0,0,0, 1,4'b1100,1,0,0);
    addVec(0,1,0,0,0,0, 2,4'b0000,2,1,0);
    addVec(0,0,0,0,0,0, 2,4'b0000,2,1,0);
    addVec(0,1,0,0,0,0, 2,4'b0000,2,1,1);
    addVec(0,0,1,3,0,0, 1,4'b1111,0,0,0);
    addVec(0,1,0,0,0,0, 2,4'b0000,1,1,0);
    addVec(0,0,1,0,0,0, 1,4'b0001,0,0,0);
    for (int i = 0; i < 10; i++) addVec(0,1,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,1,1,0,0,0, 1,4'b0001,0,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0001,0,0,0);
    addVec(0,1,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0010,1,0,0);
    addVec(0,1,0,0,0,0, 1,4'b0100,2,0,0);
    addVec(0,0,0,0,1,0, 3,4'b0000,2,0,0);
    addVec(0,1,0,0,0,0, 3,4'b0000,2,0,0);
    addVec(0,0,0,0,0,0, 3,4'b0000,2,0,0);
    addVec(0,0,0,0,0,1, 4,4'b0000,2,0,0);
    addVec(0,0,0,0,1,1, 4,4'b0000,2,0,0);
    addVec(0,1,1,0,0,0, 1,4'b0001,0,0,0);
    addVec(0,0,0,0,0,0, 1,4'b0001,0,0,0);
    addVec(1,1,1,1,0,0, 0,4'b0000,0,0,0);
    addVec(0,1,0,0,0,0, 0,4'b0000,0,0,0);
    addVec(0,1,1,2,0,0, 1,4'b1111,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].trig, vecs[i].st, vecs[i].md, vecs[i].stp, vecs[i].rdo);
      checkOutput($sformatf("vec%0d state", i), current_state, vecs[i].e_state);
      checkOutput($sformatf("vec%0d buf_en", i), buf_en, vecs[i].e_en);
      checkOutput($sformatf("vec%0d cnt", i), trigger_cnt, vecs[i].e_cnt);
      checkOutput($sformatf("vec%0d stop_req", i), STOP_REQUEST, vecs[i].e_sreq);
      checkOutput($sformatf("vec%0d overflow", i), overflow, vecs[i].e_ovf);
    end

    modelStep(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit r, t, s, sp, rd;
      int md;
      r  = ($urandom_range(0, 199) == 0);
      t  = ($urandom_range(0, 1) == 1);
      s  = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 49) == 0);
      md = $urandom_range(0, 3);
      modelStep(r, t, s, md, sp, rd);
      applyStimulus(r, t, s, 2'(md), sp, rd);
      checkOutput($sformatf("rnd%0d state", c), current_state, mState);
      checkOutput($sformatf("rnd%0d buf_en", c), buf_en, modelEn());
      checkOutput($sformatf("rnd%0d cnt", c), trigger_cnt, mCnt);
      checkOutput($sformatf("rnd%0d stop_req", c), STOP_REQUEST, int'(mSreq));
      checkOutput($sformatf("rnd%0d overflow", c), overflow, int'(mOvf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
